// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Shares one serial bus among NUM_INIT initiators. Ownership is round-robin,
// every handover leaves exactly one cycle with no grant, and an owner that
// holds the bus for MAX_HOLD cycles while someone else is waiting is forced
// off. A single split slot lets the addressed target push the current owner
// off the bus. That owner is then parked. When the target signals that it can
// resume, the parked owner is granted ahead of the round-robin order.
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   rst            asynchronous, active-high reset
//   req            per-initiator request level, held for the whole transaction
//   target_split   one-cycle pulse: target splits the current owner
//   split_resume   one-cycle pulse: split target is ready to complete
//   grant          one-hot (or zero) bus grant, registered
//   owner_id       index of the granted initiator, meaningful while bus_busy
//   bus_busy       high while any grant bit is set
//   split_pending  high while a split owner is parked
//   split_overflow one-cycle pulse when a split is refused (slot already full)
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int NUM_INIT = 2,
  parameter int MAX_HOLD = 64,
  parameter int IDW      = $clog2(NUM_INIT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_INIT-1:0] req,
  input  logic                target_split,
  input  logic                split_resume,
  output logic [NUM_INIT-1:0] grant,
  output logic [IDW-1:0]      owner_id,
  output logic                bus_busy,
  output logic                split_pending,
  output logic                split_overflow
);

  // The hold counter only needs to reach MAX_HOLD. It keeps one bit when the
  // timeout is disabled.
  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_INIT-1:0]  grant_q, grant_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q, ovf_d;
  logic [HCW-1:0]       hold_q, hold_d;
  logic [IDW-1:0]       rr_q, rr_d;
  logic                 pend_q, pend_d;
  logic [IDW-1:0]       parked_q, parked_d;
  logic                 resume_q, resume_d;

  logic [NUM_INIT-1:0]  eligible;
  logic                 owner_req;
  logic                 parked_req;
  logic                 other_waiting;
  logic                 win_valid;
  logic                 win_parked;
  logic [IDW-1:0]       win_id;
  logic [IDW-1:0]       scan_idx;
  logic                 grant_new;
  logic                 release_bus;
  logic                 park_owner;
  logic                 overflow_now;

  // Request qualification. A parked initiator stays invisible to the
  // arbiter until its target has signalled resume. The owner's and the
  // parked initiator's request bits are picked out with a compare loop.
  // This keeps non-power-of-two NUM_INIT safe from out-of-range selects.
  always_comb begin
    eligible      = '0;
    owner_req     = 1'b0;
    parked_req    = 1'b0;
    other_waiting = 1'b0;
    for (int i = 0; i < NUM_INIT; i++) begin
      eligible[i] = req[i] && !(pend_q && !resume_q && (parked_q == IDW'(i)));
      if (owner_q == IDW'(i)) begin
        owner_req = req[i];
      end
      if (parked_q == IDW'(i)) begin
        parked_req = req[i];
      end
      if (eligible[i] && (owner_q != IDW'(i))) begin
        other_waiting = 1'b1;
      end
    end
  end

  // Winner selection. A resumed parked initiator that is still requesting
  // wins outright. Otherwise the upward search from rr_ptr picks the winner.
  // The search loop runs from the far end back to rr_ptr, so the last match
  // it sees is the one closest to rr_ptr.
  always_comb begin
    win_valid  = 1'b0;
    win_parked = 1'b0;
    win_id     = '0;
    scan_idx   = '0;
    if (pend_q && resume_q && parked_req) begin
      win_valid  = 1'b1;
      win_parked = 1'b1;
      win_id     = parked_q;
    end else begin
      for (int k = NUM_INIT - 1; k >= 0; k--) begin
        scan_idx = IDW'((int'(rr_q) + k) % NUM_INIT);
        if (eligible[scan_idx]) begin
          win_valid = 1'b1;
          win_id    = scan_idx;
        end
      end
    end
  end

  // State register plus every registered output and bookkeeping field.
  // Reset is asynchronous, so an in-flight grant drops at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      hold_q   <= '0;
      rr_q     <= '0;
      pend_q   <= 1'b0;
      parked_q <= '0;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      hold_q   <= hold_d;
      rr_q     <= rr_d;
      pend_q   <= pend_d;
      parked_q <= parked_d;
      resume_q <= resume_d;
    end
  end

  // Next-state logic. IDLE and TURN both act the same way at the next edge:
  // grant a winner or stay idle. Because TURN shows no grant for exactly one
  // cycle, every handover passes through zero.
  //
  // The forced release only fires when the counter is exactly one below
  // MAX_HOLD. The counter saturates at MAX_HOLD. So once an owner has held
  // the bus past the window with nobody waiting, a later request does not
  // cut it off. That owner keeps the bus until it drops req or is split.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    rr_d         = rr_q;
    pend_d       = pend_q;
    parked_d     = parked_q;
    resume_d     = resume_q;
    grant_new    = 1'b0;
    release_bus  = 1'b0;
    park_owner   = 1'b0;
    overflow_now = 1'b0;

    case (state_q)
      IDLE, TURN: begin
        if (win_valid) begin
          state_d   = BUSY;
          hold_d    = '0;
          grant_new = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      BUSY: begin
        if (!owner_req) begin
          release_bus = 1'b1;
        end else if (target_split) begin
          if (!pend_q) begin
            park_owner  = 1'b1;
            release_bus = 1'b1;
          end else begin
            overflow_now = 1'b1;
          end
        end else if ((MAX_HOLD != 0) && (int'(hold_q) == MAX_HOLD - 1) &&
                     other_waiting) begin
          release_bus = 1'b1;
        end

        if (release_bus) begin
          state_d = TURN;
          rr_d    = (owner_q == IDW'(NUM_INIT - 1)) ? '0 : owner_q + 1'b1;
        end else if (int'(hold_q) < MAX_HOLD) begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Split slot bookkeeping.
    // - Granting the parked initiator retires the slot. rr_ptr is left
    //   alone in that case.
    // - A new park can only happen while the slot is empty.
    // - An abandoned parked request empties the slot.
    // - A resume only counts while something is parked.
    if (grant_new && win_parked) begin
      pend_d   = 1'b0;
      resume_d = 1'b0;
    end else if (park_owner) begin
      pend_d   = 1'b1;
      parked_d = owner_q;
      resume_d = 1'b0;
    end else if (pend_q && !parked_req) begin
      pend_d   = 1'b0;
      resume_d = 1'b0;
    end else if (pend_q && split_resume) begin
      resume_d = 1'b1;
    end
  end

  // Output logic. It computes the values the registered outputs take at the
  // next edge. A fresh grant selects the winner. A continuing BUSY keeps the
  // current owner. Anything else clears the grant.
  always_comb begin
    grant_d = '0;
    owner_d = owner_q;
    busy_d  = 1'b0;
    ovf_d   = overflow_now;
    if (state_d == BUSY) begin
      busy_d = 1'b1;
      if (grant_new) begin
        owner_d = win_id;
        for (int i = 0; i < NUM_INIT; i++) begin
          grant_d[i] = (win_id == IDW'(i));
        end
      end else begin
        grant_d = grant_q;
      end
    end
  end

  assign grant          = grant_q;
  assign owner_id       = owner_q;
  assign bus_busy       = busy_q;
  assign split_pending  = pend_q;
  assign split_overflow = ovf_q;

endmodule
